// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  typedef enum logic {
    FS_BOOT,
    FS_RUN
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; head word is visible combinationally
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage carries no reset; consumers gate the head with empty_o.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC owner, credit-limited imem requester and decode buffer
// Optional FETCH_MISALIGN_CHK_EN adds o_fetch_misalign for unaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_pc_branch,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            o_fetch_misalign,
`endif
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  output logic            o_if_valid,
  input  logic            i_id_ready,
  output logic [31:0]     o_if_instr,
  output logic [XLEN-1:0] o_if_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW = XLEN + 32;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, redir_pc, tag_rdata;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, ent_cnt, tag_cnt;
  logic [EW-1:0]   ent_rdata;
  logic [CW:0]     inflight;
  logic            ent_full, ent_empty, tag_full, tag_empty;
  logic            fetch_block, credit, grant, resp_keep, pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               mis_q <= 1'b0;
    else if (i_branch_taken) mis_q <= |i_pc_branch[1:0];
  end
  assign o_fetch_misalign = mis_q;
  assign fetch_block      = mis_q;
  assign redir_pc         = i_pc_branch;
`else
  assign fetch_block = 1'b0;
  assign redir_pc    = {i_pc_branch[XLEN-1:2], 2'b00};
`endif

  // A same-cycle pop frees a slot, which is what sustains one instruction per cycle.
  assign pop      = !ent_empty && i_id_ready && !i_branch_taken;
  assign inflight = {1'b0, ent_cnt} + {1'b0, out_q} - (CW+1)'(pop);
  assign credit   = inflight < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    o_imem_req = 1'b0;
    case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN:  o_imem_req = credit && !i_branch_taken && !fetch_block;
      default: state_d = FS_BOOT;
    endcase
  end

  assign grant     = o_imem_req && i_imem_gnt;
  assign resp_keep = i_imem_rvalid && (drop_q == '0) && !i_branch_taken;

  always_comb begin
    out_d  = out_q + CW'(grant) - CW'(i_imem_rvalid);
    drop_d = drop_q;
    pc_d   = pc_q;
    if (i_branch_taken) begin
      drop_d = out_d;
      pc_d   = redir_pc;
    end else begin
      if (i_imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (grant) pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(grant), .pop_i(resp_keep),
    .flush_i(i_branch_taken), .wdata_i(pc_q), .rdata_o(tag_rdata),
    .count_o(tag_cnt), .full_o(tag_full), .empty_o(tag_empty)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_entry_q (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(resp_keep), .pop_i(pop),
    .flush_i(i_branch_taken), .wdata_i({tag_rdata, i_imem_rdata}), .rdata_o(ent_rdata),
    .count_o(ent_cnt), .full_o(ent_full), .empty_o(ent_empty)
  );

  logic unused_flags;
  assign unused_flags = ^{tag_cnt, tag_full, tag_empty, ent_full};

  assign o_imem_addr = pc_q;
  assign o_if_valid  = !ent_empty;
  assign o_if_instr  = ent_empty ? '0 : ent_rdata[31:0];
  assign o_if_pc     = ent_empty ? '0 : ent_rdata[EW-1:32];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus redirect and variable-latency sequences
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rv;
  logic [31:0] rdata;
  logic        val;
  logic        rdy;
  logic [31:0] instr;
  logic [31:0] ifpc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int ncmp = 0;
  int nfail = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_branch_taken(br), .i_pc_branch(tgt),
    .o_imem_req(req), .o_imem_addr(addr),
`ifdef FETCH_MISALIGN_CHK_EN
    .o_fetch_misalign(misalign),
`endif
    .i_imem_gnt(gnt), .i_imem_rvalid(rv), .i_imem_rdata(rdata),
    .o_if_valid(val), .i_id_ready(rdy), .o_if_instr(instr), .o_if_pc(ifpc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] ins(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic b, input logic [31:0] t, input logic g,
                              input logic r, input logic [31:0] d, input logic y,
                              input logic eq, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.br = b; v.tgt = t; v.gnt = g; v.rv = r; v.rdata = d; v.rdy = y;
    v.e_req = eq; v.e_addr = ea; v.e_val = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic b, input logic [31:0] t, input logic g,
                       input logic r, input logic [31:0] d, input logic y);
    br = b; tgt = t; gnt = g; rv = r; rdata = d; rdy = y;
  endtask

  // Leaves the bench at a negedge with reset just released: the DUT is in BOOT.
  task automatic do_reset(input bit check);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    if (check) begin
      chk("rst.req", {31'b0, req}, 0);
      chk("rst.addr", addr, 0);
      chk("rst.val", {31'b0, val}, 0);
      chk("rst.instr", instr, 0);
      chk("rst.pc", ifpc, 0);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("rst.mis", {31'b0, misalign}, 0);
`endif
    end
    rst = 1'b0;
  endtask

  logic [31:0] mq_addr[$];
  int          mq_due[$];

  initial begin
    vt.push_back(mk(0, 0,      1, 0, 0,           1,  0, 32'h000, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 0, 0,           1,  1, 32'h000, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h0),  1,  1, 32'h004, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h4),  1,  1, 32'h008, 1, 32'h000, ins(32'h0)));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h8),  1,  1, 32'h00C, 1, 32'h004, ins(32'h4)));
    vt.push_back(mk(0, 0,      0, 1, ins(32'hC),  1,  1, 32'h010, 1, 32'h008, ins(32'h8)));
    vt.push_back(mk(0, 0,      0, 0, 0,           0,  1, 32'h010, 1, 32'h00C, ins(32'hC)));
    vt.push_back(mk(0, 0,      1, 0, 0,           0,  1, 32'h010, 1, 32'h00C, ins(32'hC)));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h10), 0,  0, 32'h014, 1, 32'h00C, ins(32'hC)));
    vt.push_back(mk(0, 0,      1, 0, 0,           0,  0, 32'h014, 1, 32'h00C, ins(32'hC)));
    vt.push_back(mk(0, 0,      1, 0, 0,           1,  1, 32'h014, 1, 32'h00C, ins(32'hC)));
    vt.push_back(mk(0, 0,      1, 0, 0,           1,  1, 32'h018, 1, 32'h010, ins(32'h10)));
    vt.push_back(mk(1, 32'h100, 1, 0, 0,          1,  0, 32'h01C, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h14), 1,  0, 32'h100, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h18), 1,  1, 32'h100, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h100), 1, 1, 32'h104, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 1, ins(32'h104), 1, 1, 32'h108, 1, 32'h100, ins(32'h100)));
    vt.push_back(mk(1, 32'h200, 1, 1, ins(32'h108), 1, 0, 32'h10C, 1, 32'h104, ins(32'h104)));
    vt.push_back(mk(0, 0,      0, 0, 0,           1,  1, 32'h200, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      1, 0, 0,           1,  1, 32'h200, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      0, 1, ins(32'h200), 1, 1, 32'h204, 0, 32'h000, 0));
    vt.push_back(mk(0, 0,      0, 0, 0,           1,  1, 32'h204, 1, 32'h200, ins(32'h200)));

    do_reset(1);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].br, vt[i].tgt, vt[i].gnt, vt[i].rv, vt[i].rdata, vt[i].rdy);
      #1;
      chk($sformatf("v%0d.req", i), {31'b0, req}, {31'b0, vt[i].e_req});
      chk($sformatf("v%0d.addr", i), addr, vt[i].e_addr);
      chk($sformatf("v%0d.val", i), {31'b0, val}, {31'b0, vt[i].e_val});
      chk($sformatf("v%0d.pc", i), ifpc, vt[i].e_pc);
      chk($sformatf("v%0d.instr", i), instr, vt[i].e_instr);
      @(negedge clk);
    end

    // Redirect during BOOT to an unaligned target, then back-to-back redirects.
    do_reset(0);
    drive(1, 32'h102, 0, 0, 0, 0);
    #1 chk("boot.req", {31'b0, req}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis.flag", {31'b0, misalign}, 1);
    chk("mis.req", {31'b0, req}, 0);
    chk("mis.addr", addr, 32'h102);
    @(negedge clk);
    #1 chk("mis.hold", {31'b0, req}, 0);
    @(negedge clk);
    drive(1, 32'h200, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mis.clr", {31'b0, misalign}, 0);
    chk("mis.resume", {31'b0, req}, 1);
    chk("mis.raddr", addr, 32'h200);
`else
    chk("align.req", {31'b0, req}, 1);
    chk("align.addr", addr, 32'h100);
`endif
    @(negedge clk);
    drive(1, 32'h300, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'h404, 0, 0, 0, 0);
    #1 chk("b2b.req0", {31'b0, req}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("b2b.req", {31'b0, req}, 1);
    chk("b2b.addr", addr, 32'h404);

    // Sparse grants, 1-4 cycle in-order latency, random decode stalls.
    do_reset(0);
    mq_addr.delete();
    mq_due.delete();
    begin
      logic [31:0] exp_pc = 0;
      logic [31:0] exp_fetch = 0;
      int          last_due = 0;
      int          got = 0;
      for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
        br = 0; tgt = 0;
        gnt = (cyc % 3 == 0);
        rdy = ($urandom_range(0, 3) != 0);
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
          rv = 1; rdata = ins(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          rv = 0; rdata = 0;
        end
        #1;
        if (req && gnt) begin
          int due = cyc + int'($urandom_range(1, 4));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          chk("lat.faddr", addr, exp_fetch);
          mq_addr.push_back(addr);
          mq_due.push_back(due);
          exp_fetch += 4;
        end
        if (val && rdy) begin
          chk($sformatf("lat.pc%0d", got), ifpc, exp_pc);
          chk($sformatf("lat.in%0d", got), instr, ins(exp_pc));
          exp_pc += 4;
          got++;
        end
        @(negedge clk);
      end
      chk("lat.count", got, 20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
